// File: rtl/vga_pkg.sv
// Shared VGA/frame-buffer constants and host-port FSM encoding for the
// 640x480 display path. The frame buffer is a 4x-downscaled RGB332 image.
package vga_pkg;

    localparam int H_VIS      = 640;
    localparam int V_VIS      = 480;
    localparam int H_TOTAL    = 800;
    localparam int V_TOTAL    = 525;

    localparam int SCALE_LOG2 = 2;
    localparam int FB_W       = H_VIS >> SCALE_LOG2;
    localparam int FB_H       = V_VIS >> SCALE_LOG2;
    localparam int COLOR_W    = 8;
    localparam int ADDR_W     = 15;

    localparam logic [ADDR_W-1:0] FB_WORDS = ADDR_W'(FB_W * FB_H);

    typedef enum logic {
        HOST_IDLE = 1'b0,
        HOST_BUSY = 1'b1
    } host_state_e;

    // Host addresses past the last frame-buffer word never reach the RAM.
    function automatic logic fb_addr_ok(input logic [ADDR_W-1:0] addr);
        return addr < FB_WORDS;
    endfunction

endpackage

// File: rtl/vram_addr_gen.sv
// Screen coordinate to linear frame-buffer address: (y>>2)*160 + (x>>2),
// built as (y<<7)+(y<<5)+x so no multiplier is needed.
module vram_addr_gen
    import vga_pkg::*;
(
    input  logic [9:0]        pixel_x_i,
    input  logic [9:0]        pixel_y_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] xs_s;
    logic [ADDR_W-1:0] ys_s;

    assign xs_s   = ADDR_W'(pixel_x_i >> SCALE_LOG2);
    assign ys_s   = ADDR_W'(pixel_y_i >> SCALE_LOG2);
    assign addr_o = (ys_s << 7) + (ys_s << 5) + xs_s;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: phase 0 of every visible pixel belongs to
// scan-out, all other RAM slots serve the host with a one-cycle ack.
module vram_arbiter
    import vga_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               p_tick,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic               video_on,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               host_req,
    input  logic               host_we,
    input  logic [ADDR_W-1:0]  host_addr,
    input  logic [COLOR_W-1:0] host_wdata,
    output logic               host_ack,
    output logic [COLOR_W-1:0] host_rdata,
    output logic               ram_en,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [COLOR_W-1:0] ram_wdata,
    input  logic [COLOR_W-1:0] ram_rdata,
    output logic [COLOR_W-1:0] rgb,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               vblank,
    output logic               vblank_start
);

    logic [1:0]         phase_q, phase_d;
    logic               synced_q, synced_d;
    host_state_e        state_q, state_d;
    logic               rd_q, rd_d;
    logic               disp_vis_q, disp_vis_d;
    logic [COLOR_W-1:0] rgb_q, rgb_d;
    logic               hsync_q, vsync_q;
    logic               vblank_q, vblank_d;
    logic               vblank_start_q, vblank_start_d;

    logic [ADDR_W-1:0]  disp_addr_s;
    logic               disp_slot_s;
    logic               grant_s;
    logic               host_ok_s;

    vram_addr_gen u_addr_gen (
        .pixel_x_i (pixel_x),
        .pixel_y_i (pixel_y),
        .addr_o    (disp_addr_s)
    );

    // Phase tracking, host FSM and display pipeline next state
    always_comb begin
        phase_d        = p_tick ? 2'd0 : phase_q + 2'd1;
        // Scan-out stays off after reset until the first pixel boundary is seen.
        synced_d       = synced_q | p_tick;
        disp_slot_s    = synced_q && (phase_q == 2'd0) && video_on;
        host_ok_s      = fb_addr_ok(host_addr);
        grant_s        = 1'b0;
        state_d        = state_q;
        rd_d           = rd_q;
        disp_vis_d     = disp_vis_q;
        rgb_d          = rgb_q;
        vblank_d       = (pixel_y >= 10'(V_VIS));
        vblank_start_d = vblank_d && !vblank_q;

        case (state_q)
            HOST_IDLE: begin
                if (host_req && !disp_slot_s && !reset) begin
                    grant_s = 1'b1;
                    state_d = HOST_BUSY;
                    rd_d    = host_ok_s && !host_we;
                end else begin
                    state_d = HOST_IDLE;
                end
            end
            HOST_BUSY: state_d = HOST_IDLE;
            default:   state_d = HOST_IDLE;
        endcase

        if (phase_q == 2'd0) begin
            disp_vis_d = disp_slot_s;
        end else begin
            disp_vis_d = disp_vis_q;
        end

        if (phase_q == 2'd1) begin
            rgb_d = disp_vis_q ? ram_rdata : {COLOR_W{1'b0}};
        end else begin
            rgb_d = rgb_q;
        end
    end

    // RAM port mux: display slot first, then a granted in-range host access
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = {ADDR_W{1'b0}};
        ram_wdata = {COLOR_W{1'b0}};
        if (disp_slot_s) begin
            ram_en   = 1'b1;
            ram_addr = disp_addr_s;
        end else if (grant_s && host_ok_s) begin
            ram_en    = 1'b1;
            ram_we    = host_we;
            ram_addr  = host_addr;
            ram_wdata = host_wdata;
        end else begin
            ram_en = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q        <= 2'd0;
            synced_q       <= 1'b0;
            state_q        <= HOST_IDLE;
            rd_q           <= 1'b0;
            disp_vis_q     <= 1'b0;
            rgb_q          <= {COLOR_W{1'b0}};
            hsync_q        <= 1'b0;
            vsync_q        <= 1'b0;
            vblank_q       <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            synced_q       <= synced_d;
            state_q        <= state_d;
            rd_q           <= rd_d;
            disp_vis_q     <= disp_vis_d;
            rgb_q          <= rgb_d;
            hsync_q        <= hsync_in;
            vsync_q        <= vsync_in;
            vblank_q       <= vblank_d;
            vblank_start_q <= vblank_start_d;
        end
    end

    // The RAM answers one clock after the grant, exactly in the ack cycle.
    assign host_ack     = (state_q == HOST_BUSY);
    assign host_rdata   = (host_ack && rd_q) ? ram_rdata : {COLOR_W{1'b0}};
    assign rgb          = rgb_q;
    assign hsync_out    = hsync_q;
    assign vsync_out    = vsync_q;
    assign vblank       = vblank_q;
    assign vblank_start = vblank_start_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter with a behavioural slot/pixel model and a
// synchronous RAM preloaded with mem[a] = a[7:0].
module tb_vram_arbiter;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        reset, p_tick, video_on, hsync_in, vsync_in;
    logic [9:0]  pixel_x, pixel_y;
    logic        host_req, host_we, host_ack;
    logic [14:0] host_addr, ram_addr;
    logic [7:0]  host_wdata, host_rdata, ram_wdata, rgb;
    logic [7:0]  ram_rdata = 8'd0;
    logic        ram_en, ram_we, hsync_out, vsync_out, vblank, vblank_start;

    logic [7:0]  mem [0:32767];

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .vblank(vblank), .vblank_start(vblank_start)
    );

    // Frame-buffer RAM, one clock read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model state
    int m_phase, m_ack_data, m_disp_data, m_rgb;
    bit m_synced, m_busy, m_hs, m_vs, m_vb, m_vbs;
    int m_mem [FB_W*FB_H];

    int pidx = 0;
    int cx = 0;
    int cy = 0;
    bit ack_seen = 1'b0;

    function automatic int fb_index(input int x, input int y);
        return (y / 4) * FB_W + x / 4;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_synced = 0; m_busy = 0; m_ack_data = 0;
        m_disp_data = 0; m_rgb = 0; m_hs = 0; m_vs = 0; m_vb = 0; m_vbs = 0;
    endtask

    // Drive this cycle's inputs, then compare every output with the model.
    task automatic pre();
        bit disp, grant, inr, e_en;
        p_tick   = (pidx == 3);
        pixel_x  = 10'(cx);
        pixel_y  = 10'(cy);
        video_on = (cx < 640) && (cy < 480);
        hsync_in = 1'($urandom);
        vsync_in = 1'($urandom);
        #1;
        if (reset) model_reset();
        disp  = !reset && m_synced && (m_phase == 0) && video_on;
        grant = !reset && !m_busy && host_req && !disp;
        inr   = (int'(host_addr) < FB_W*FB_H);
        e_en  = disp || (grant && inr);
        check_val("ram_en", ram_en, e_en);
        if (e_en) begin
            check_val("ram_we", ram_we, disp ? 0 : host_we);
            check_val("ram_addr", ram_addr, disp ? fb_index(cx, cy) : int'(host_addr));
            if (!disp && host_we) check_val("ram_wdata", ram_wdata, host_wdata);
        end
        check_val("host_ack", host_ack, m_busy);
        check_val("host_rdata", host_rdata, m_busy ? m_ack_data : 0);
        check_val("rgb", rgb, m_rgb);
        check_val("hsync_out", hsync_out, m_hs);
        check_val("vsync_out", vsync_out, m_vs);
        check_val("vblank", vblank, m_vb);
        check_val("vblank_start", vblank_start, m_vbs);
        ack_seen = host_ack;
    endtask

    // Advance the model across the clock edge and move to the next cycle.
    task automatic post();
        bit disp, grant, inr;
        disp  = !reset && m_synced && (m_phase == 0) && video_on;
        grant = !reset && !m_busy && host_req && !disp;
        inr   = (int'(host_addr) < FB_W*FB_H);
        if (!reset) begin
            if (grant) begin
                m_ack_data = (inr && !host_we) ? m_mem[host_addr] : 0;
                if (inr && host_we) m_mem[host_addr] = host_wdata;
            end
            m_busy = grant;
            if (m_phase == 1) m_rgb = m_disp_data;
            if (m_phase == 0) m_disp_data = disp ? m_mem[fb_index(cx, cy)] : 0;
            m_vbs    = (cy >= 480) && !m_vb;
            m_vb     = (cy >= 480);
            m_hs     = hsync_in;
            m_vs     = vsync_in;
            m_synced = m_synced || p_tick;
            m_phase  = p_tick ? 0 : (m_phase + 1) % 4;
        end
        @(posedge clk);
        @(negedge clk);
        pidx = (pidx + 1) % 4;
        if (ack_seen) host_req = 1'b0;
    endtask

    task automatic tick();
        pre();
        post();
    endtask

    task automatic to_phase0();
        while (pidx != 0) tick();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (pidx == 0) begin
                cx = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 639) : $urandom_range(640, 799);
                cy = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 479) : $urandom_range(480, 524);
            end
            if (!host_req && $urandom_range(0, 2) == 0) begin
                host_req   = 1'b1;
                host_we    = 1'($urandom_range(0, 1));
                host_addr  = ($urandom_range(0, 9) == 0) ? 15'(19200 + $urandom_range(0, 13567))
                                                         : 15'($urandom_range(0, 19199));
                host_wdata = 8'($urandom);
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = 15'd0; host_wdata = 8'd0;
        for (int a = 0; a < 32768; a++) mem[a] = 8'(a);
        for (int a = 0; a < FB_W*FB_H; a++) m_mem[a] = a % 256;
        model_reset();
        @(negedge clk);

        // Power-on reset
        pre();
        check_val("rst_rgb", rgb, 0);
        check_val("rst_ram_en", ram_en, 0);
        post();
        reset = 1'b0;
        repeat (8) tick();

        // Scaled address and two-clock colour latency
        to_phase0();
        cx = 8; cy = 4;
        pre();
        check_val("t2_addr", ram_addr, 162);
        post();
        tick();
        pre();
        check_val("t2_rgb", rgb, 162);
        post();

        // Host write collides with a display slot
        to_phase0();
        cx = 100; cy = 50;
        host_req = 1'b1; host_we = 1'b1; host_addr = 15'd500; host_wdata = 8'h5A;
        pre();
        check_val("t3_p0_we", ram_we, 0);
        post();
        pre();
        check_val("t3_grant_addr", ram_addr, 500);
        post();
        pre();
        check_val("t3_ack", host_ack, 1);
        post();
        check_val("t3_mem", mem[500], 8'h5A);

        // Host read during vblank
        cx = 10; cy = 490;
        to_phase0();
        repeat (4) tick();
        host_req = 1'b1; host_we = 1'b0; host_addr = 15'd1234;
        pre();
        check_val("t4_grant_addr", ram_addr, 1234);
        post();
        pre();
        check_val("t4_rdata", host_rdata, 210);
        check_val("t4_rgb", rgb, 0);
        post();

        // Out-of-range host address
        host_req = 1'b1; host_we = 1'b0; host_addr = 15'd19200;
        pre();
        check_val("t5_ram_en", ram_en, 0);
        post();
        pre();
        check_val("t5_ack", host_ack, 1);
        check_val("t5_rdata", host_rdata, 0);
        post();

        // vblank edge and a single vblank_start pulse
        to_phase0();
        cy = 479;
        repeat (4) tick();
        cy = 480;
        tick();
        pre();
        check_val("t6_vblank", vblank, 1);
        check_val("t6_vbs", vblank_start, 1);
        post();
        pre();
        check_val("t6_vbs_once", vblank_start, 0);
        post();

        // Reset while the host access is in flight
        host_req = 1'b1; host_we = 1'b0; host_addr = 15'd77;
        tick();
        reset = 1'b1;
        pre();
        check_val("t6_rst_ack", host_ack, 0);
        post();
        host_req = 1'b0;
        tick();
        reset = 1'b0;

        // Mid-frame reset and resynchronisation on the next pixel tick
        run(400);
        host_req = 1'b0;
        cx = 320; cy = 500;
        reset = 1'b1;
        pre();
        check_val("t1_rgb", rgb, 0);
        check_val("t1_ack", host_ack, 0);
        check_val("t1_vblank", vblank, 0);
        post();
        cy = 240;
        while (pidx != 1) tick();
        reset = 1'b0;
        pre();
        check_val("t1_no_early_read", ram_en, 0);
        post();
        to_phase0();
        pre();
        check_val("t1_first_read", ram_en, 1);
        post();

        run(2000);
        reset = 1'b1;
        host_req = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        run(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
